ifu_fetch: RTL and testbench

//  Instruction fetch stage of LemonPC, directly upstream of the control decoder.

---
 rtl/ifu_fetch.sv | 148 ++++++++++++++
 tb/tb_ifu_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: holds the architectural PC, fetches one instruction per
// commit over a valid/ready request + valid response handshake, and presents a
// stable inst/pc pair downstream until commit. Halts on ebreak or fetch fault.
module ifu_fetch #(
   parameter int unsigned        XLEN           = 64,
   parameter logic [XLEN-1:0]    PC_RESET       = 64'h8000_0000,
   parameter int unsigned        TIMEOUT_CYCLES = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_data,
   input  logic             imem_rsp_err,
   output logic [31:0]      inst,
   output logic             inst_valid,
   output logic [XLEN-1:0]  pc,
   input  logic             commit,
   input  logic             pc_sel,
   input  logic [XLEN-1:0]  dnpc,
   input  logic             ebreak,
   output logic             halted,
   output logic             fetch_err
);

   localparam logic [31:0] Nop = 32'h0000_0013;

   typedef enum logic [2:0] {StIdle, StReq, StWait, StExec, StHalt} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [31:0]       inst_q, inst_d;
   logic              inst_valid_q, inst_valid_d;
   logic              halted_q, halted_d;
   logic              fetch_err_q, fetch_err_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [XLEN-1:0]   next_pc;
   logic              timeout_hit;

   // Target for the next fetch; jump targets have bit 0 forced low.
   always_comb begin
      next_pc = pc_sel ? {dnpc[XLEN-1:1], 1'b0} : pc_q + XLEN'(4);
   end

   // Timeout fires on the last allowed waiting cycle; disabled when TIMEOUT_CYCLES is 0.
   always_comb begin
      timeout_hit = 1'b0;
      if (TIMEOUT_CYCLES != 0) begin
         timeout_hit = (cnt_q == 32'(TIMEOUT_CYCLES - 1));
      end
   end

   // Next-state logic for the fetch sequencer.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      halted_d     = halted_q;
      fetch_err_d  = fetch_err_q;
      cnt_d        = cnt_q;
      unique case (state_q)
         StIdle: state_d = StReq;
         StReq: begin
            if (imem_req_ready) begin
               state_d = StWait;
               cnt_d   = '0;
            end
         end
         StWait: begin
            if (imem_rsp_valid) begin
               if (imem_rsp_err) begin
                  fetch_err_d = 1'b1;
                  halted_d    = 1'b1;
                  state_d     = StHalt;
               end else begin
                  inst_d       = imem_rsp_data;
                  inst_valid_d = 1'b1;
                  state_d      = StExec;
               end
            end else if (timeout_hit) begin
               fetch_err_d = 1'b1;
               halted_d    = 1'b1;
               state_d     = StHalt;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StExec: begin
            if (commit) begin
               inst_valid_d = 1'b0;
               if (ebreak) begin
                  halted_d = 1'b1;
                  state_d  = StHalt;
               end else if (next_pc[1]) begin
                  // Misaligned target: pc stays on the offending instruction.
                  fetch_err_d = 1'b1;
                  halted_d    = 1'b1;
                  state_d     = StHalt;
               end else begin
                  pc_d    = next_pc;
                  state_d = StReq;
               end
            end
         end
         StHalt: begin
            inst_valid_d = 1'b0;
            halted_d     = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         pc_q         <= PC_RESET;
         inst_q       <= Nop;
         inst_valid_q <= 1'b0;
         halted_q     <= 1'b0;
         fetch_err_q  <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         halted_q     <= halted_d;
         fetch_err_q  <= fetch_err_d;
         cnt_q        <= cnt_d;
      end
   end

   // Outputs are decoded from registered state only.
   always_comb begin
      imem_req_valid = (state_q == StReq);
      imem_req_addr  = pc_q;
      inst           = inst_q;
      inst_valid     = inst_valid_q;
      pc             = pc_q;
      halted         = halted_q;
      fetch_err      = fetch_err_q;
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: drives a hand-scripted memory and execute stage.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic [31:0] inst;
   logic        inst_valid;
   logic [63:0] pc;
   logic        commit;
   logic        pc_sel;
   logic [63:0] dnpc;
   logic        ebreak;
   logic        halted;
   logic        fetch_err;

   int checks = 0;
   int passed = 0;
   int req_seen;

   ifu_fetch #(
      .XLEN           (64),
      .PC_RESET       (64'h8000_0000),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .inst           (inst),
      .inst_valid     (inst_valid),
      .pc             (pc),
      .commit         (commit),
      .pc_sel         (pc_sel),
      .dnpc           (dnpc),
      .ebreak         (ebreak),
      .halted         (halted),
      .fetch_err      (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Wait for a request, accept it, answer next cycle with data, check decode view.
   task automatic do_fetch(input string tag, input logic [63:0] addr, input logic [31:0] data);
      for (int i = 0; i < 20 && !imem_req_valid; i++) tick();
      check({tag, ".req_valid"}, imem_req_valid, 1'b1);
      check({tag, ".req_addr"}, imem_req_addr, addr);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      check({tag, ".req_dropped"}, imem_req_valid, 1'b0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      tick();
      imem_rsp_valid = 1'b0;
      check({tag, ".inst_valid"}, inst_valid, 1'b1);
      check({tag, ".inst"}, inst, data);
      check({tag, ".pc"}, pc, addr);
   endtask

   task automatic do_commit(input logic sel, input logic [63:0] target, input logic eb);
      commit = 1'b1;
      pc_sel = sel;
      dnpc   = target;
      ebreak = eb;
      tick();
      commit = 1'b0;
      pc_sel = 1'b0;
      ebreak = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      commit         = 1'b0;
      pc_sel         = 1'b0;
      dnpc           = '0;
      ebreak         = 1'b0;
      tick();
      tick();

      // T1: reset state, then first fetch
      check("rst.req_valid", imem_req_valid, 1'b0);
      check("rst.req_addr", imem_req_addr, 64'h8000_0000);
      check("rst.inst", inst, 32'h0000_0013);
      check("rst.inst_valid", inst_valid, 1'b0);
      check("rst.halted", halted, 1'b0);
      check("rst.fetch_err", fetch_err, 1'b0);
      rst_n = 1'b1;
      tick();
      check("t1.req_after_idle", imem_req_valid, 1'b1);
      do_fetch("t1", 64'h8000_0000, 32'h0010_0093);

      // T2: sequential and jump next-PC
      do_commit(1'b0, 64'h0, 1'b0);
      check("t2.req_next_cycle", imem_req_valid, 1'b1);
      check("t2.inst_valid_clr", inst_valid, 1'b0);
      do_fetch("t2a", 64'h8000_0004, 32'h0000_0013);
      do_commit(1'b1, 64'h8000_0011, 1'b0);
      do_fetch("t2b", 64'h8000_0010, 32'h0000_0013);

      // T3: request held while memory stalls
      do_commit(1'b1, 64'h8000_000C, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("t3.stall_valid", imem_req_valid, 1'b1);
         check("t3.stall_addr", imem_req_addr, 64'h8000_000C);
         tick();
      end
      do_fetch("t3", 64'h8000_000C, 32'h0010_0073);

      // T4: ebreak halts with pc on the ebreak
      do_commit(1'b0, 64'h0, 1'b1);
      check("t4.halted", halted, 1'b1);
      check("t4.pc", pc, 64'h8000_000C);
      check("t4.inst_valid", inst_valid, 1'b0);
      check("t4.fetch_err", fetch_err, 1'b0);
      req_seen = 0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b1;
      commit         = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (imem_req_valid) req_seen++;
         tick();
      end
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      commit         = 1'b0;
      check("t4.no_req_in_halt", 64'(req_seen), 64'd0);
      check("t4.still_halted", halted, 1'b1);
      check("t4.halt_inst_valid", inst_valid, 1'b0);

      // T4b: response error
      do_reset();
      tick();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_err   = 1'b1;
      tick();
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      check("t4b.fetch_err", fetch_err, 1'b1);
      check("t4b.halted", halted, 1'b1);
      check("t4b.inst_valid", inst_valid, 1'b0);

      // T5: timeout after 8 waiting cycles
      do_reset();
      check("t5.rst_err_clr", fetch_err, 1'b0);
      check("t5.rst_halt_clr", halted, 1'b0);
      tick();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("t5.not_yet", halted, 1'b0);
      tick();
      check("t5.timeout_err", fetch_err, 1'b1);
      check("t5.timeout_halt", halted, 1'b1);

      // T5b: misaligned jump target
      do_reset();
      tick();
      do_fetch("t5b", 64'h8000_0000, 32'h0000_0013);
      do_commit(1'b1, 64'h8000_0002, 1'b0);
      check("t5b.fetch_err", fetch_err, 1'b1);
      check("t5b.halted", halted, 1'b1);
      check("t5b.pc_kept", pc, 64'h8000_0000);
      check("t5b.no_req", imem_req_valid, 1'b0);

      // T6: async reset mid-WAIT, stale response in REQ, PC wrap
      do_reset();
      tick();
      do_fetch("t6pre", 64'h8000_0000, 32'h0000_0013);
      do_commit(1'b1, 64'h8000_0040, 1'b0);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("t6.async_pc", pc, 64'h8000_0000);
      check("t6.async_req", imem_req_valid, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      tick();
      imem_rsp_valid = 1'b0;
      check("t6.stale_inst_valid", inst_valid, 1'b0);
      check("t6.stale_inst", inst, 32'h0000_0013);
      check("t6.stale_req_held", imem_req_valid, 1'b1);
      do_fetch("t6", 64'h8000_0000, 32'h0000_0013);
      do_commit(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
      do_fetch("t6top", 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013);
      do_commit(1'b0, 64'h0, 1'b0);
      check("t6.wrap_pc", pc, 64'h0);
      check("t6.wrap_req", imem_req_valid, 1'b1);
      check("t6.wrap_no_err", fetch_err, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
